instr_unpacker: RTL and testbench
=================================

INSTR_UNPACKER -- requirements
Module: instr_unpacker

Interface
REQ-001 Parameter CORE_INSTR_PACKET_NUM, default 4, number of 32-bit instruction slots per packet.
REQ-002 Parameter CORE_INSTR_SINGLE_WIDTH, default 32, width of one instruction slot.
REQ-003 Parameter CORE_PC_WIDTH, default 32, program counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pkt_valid_i  input  1  master presents an instruction packet.
REQ-007 pkt_ready_o  output  1  unpacker accepts packet this cycle.
REQ-008 pkt_data_i  input  PACKET_NUM*SINGLE_WIDTH (128)  packet; slot i at bits [32i+31:32i].
REQ-009 pkt_pc_i  input  CORE_PC_WIDTH  PC of slot 0.
REQ-010 pkt_start_i  input  2  index of first valid slot (branch target inside packet).
REQ-011 flush_i  input  1  discard buffered packet.
REQ-012 instr_valid_o  output  1  single instruction available.
REQ-013 instr_ready_i  input  1  downstream consumes instruction.
REQ-014 instr_o  output  SINGLE_WIDTH  current instruction.
REQ-015 instr_pc_o  output  CORE_PC_WIDTH  PC of current instruction.
REQ-016 instr_last_o  output  1  current instruction is slot PACKET_NUM-1.

Function
REQ-017 Block SHALL hold exactly one packet register, one base-PC register and a slot index counter (2 bits).
REQ-018 FSM SHALL have states IDLE (buffer empty) and DRAIN (buffer holds packet).
REQ-019 Packet transfer SHALL occur when pkt_valid_i && pkt_ready_o; instruction transfer when instr_valid_o && instr_ready_i.
REQ-020 pkt_ready_o SHALL be 1 in IDLE, 1 in DRAIN only when instr_last_o && instr_ready_i, and 0 whenever flush_i=1 or rst=1.
REQ-021 On packet transfer: store data and pkt_pc_i, index <= pkt_start_i, state <= DRAIN.
REQ-022 instr_valid_o SHALL equal (state==DRAIN); first instruction visible the cycle after packet acceptance (latency 1).
REQ-023 instr_o SHALL be slot[index]; instr_pc_o SHALL be base_pc + 4*index, modulo 2^CORE_PC_WIDTH.
REQ-024 On instruction transfer with index < PACKET_NUM-1: index <= index+1, stay DRAIN.
REQ-025 On instruction transfer with index == PACKET_NUM-1 and no simultaneous packet transfer: state <= IDLE.
REQ-026 Last-slot consume and new-packet accept in same cycle SHALL load new packet and stay DRAIN (back-to-back, no bubble).
REQ-027 While instr_valid_o && !instr_ready_i, instr_o, instr_pc_o, instr_last_o SHALL stay stable.
REQ-028 pkt_start_i=3 SHALL produce exactly one instruction (slot 3) with instr_last_o=1.
REQ-029 flush_i=1 SHALL force state <= IDLE next cycle, overriding instruction transfer and packet acceptance in that cycle; instr_valid_o is 0 the cycle after flush.
REQ-030 pkt_data_i, pkt_pc_i, pkt_start_i SHALL be ignored when no packet transfer occurs.

Reset
REQ-031 rst=1 SHALL set state IDLE, index 0, packet and base-PC registers 0 on next rising edge, regardless of state or in-flight handshakes.
REQ-032 During and after reset: instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_last_o=0; pkt_ready_o=0 while rst=1, 1 on first cycle after rst deasserts.

Verification
REQ-033 Packet {0x33,0x22,0x11,0x00 in slots 3..0}, pc 0x1000, start 0, ready always 1 -> instrs 0x00,0x11,0x22,0x33 at PCs 0x1000,0x1004,0x1008,0x100C on 4 consecutive cycles, last=1 on 4th.
REQ-034 Two packets offered back-to-back (pc 0x1000, 0x1010) with ready=1 -> 8 instructions on 8 consecutive cycles, no bubble, second packet accepted on cycle of first packet's slot 3.
REQ-035 start=2, pc 0x2000 -> exactly 2 instructions, PCs 0x2008, 0x200C; start=3 -> one instruction PC 0x200C, last=1.
REQ-036 instr_ready_i held 0 for 5 cycles at slot 1 -> outputs stable, pkt_ready_o=0, then drain resumes at slot 1.
REQ-037 flush_i pulsed during slot 2 with pkt_valid_i=1 -> no packet accepted that cycle, instr_valid_o=0 next cycle, packet accepted the following cycle.
REQ-038 pc 0xFFFFFFF8, start 0 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; rst asserted mid-drain -> instr_valid_o=0 next cycle.

Source files
------------

// File: rtl/instr_unpacker_if.sv
// Packet-in / instruction-out handshake bundle for the instruction unpacker.
interface instr_unpacker_if #(
    parameter int unsigned CORE_INSTR_PACKET_NUM   = 4,
    parameter int unsigned CORE_INSTR_SINGLE_WIDTH = 32,
    parameter int unsigned CORE_PC_WIDTH           = 32
);
    localparam int unsigned IdxW = $clog2(CORE_INSTR_PACKET_NUM);
    localparam int unsigned PktW = CORE_INSTR_PACKET_NUM * CORE_INSTR_SINGLE_WIDTH;

    logic                               pkt_valid_i;
    logic                               pkt_ready_o;
    logic [PktW-1:0]                    pkt_data_i;
    logic [CORE_PC_WIDTH-1:0]           pkt_pc_i;
    logic [IdxW-1:0]                    pkt_start_i;
    logic                               flush_i;
    logic                               instr_valid_o;
    logic                               instr_ready_i;
    logic [CORE_INSTR_SINGLE_WIDTH-1:0] instr_o;
    logic [CORE_PC_WIDTH-1:0]           instr_pc_o;
    logic                               instr_last_o;

    // Upstream fetch plus downstream consumer side
    modport master (
        output pkt_valid_i, pkt_data_i, pkt_pc_i, pkt_start_i, flush_i, instr_ready_i,
        input  pkt_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_last_o
    );

    // Unpacker side
    modport slave (
        input  pkt_valid_i, pkt_data_i, pkt_pc_i, pkt_start_i, flush_i, instr_ready_i,
        output pkt_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_last_o
    );
endinterface

// File: rtl/instr_unpacker.sv
// Splits a fetched multi-instruction packet into single instructions, one per
// handshake, starting at a selectable slot. Holds a single packet buffer and
// accepts the next packet in the same cycle the last slot is consumed.
module instr_unpacker #(
    parameter int unsigned CORE_INSTR_PACKET_NUM   = 4,
    parameter int unsigned CORE_INSTR_SINGLE_WIDTH = 32,
    parameter int unsigned CORE_PC_WIDTH           = 32
) (
    input  logic               clk,
    input  logic               rst,
    instr_unpacker_if.slave    bus_io
);
    localparam int unsigned IdxW = $clog2(CORE_INSTR_PACKET_NUM);
    localparam int unsigned PktW = CORE_INSTR_PACKET_NUM * CORE_INSTR_SINGLE_WIDTH;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CORE_INSTR_PACKET_NUM - 1);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [PktW-1:0]          pkt_q, pkt_d;
    logic [CORE_PC_WIDTH-1:0] base_pc_q, base_pc_d;
    logic [IdxW-1:0]          idx_q, idx_d;

    logic is_drain;
    logic is_last;
    logic pkt_fire;
    logic instr_fire;

    // Outputs decode straight from the buffer so they hold steady under back-pressure
    always_comb begin
        is_drain = (state_q == StDrain);
        is_last  = is_drain && (idx_q == LastIdx);

        bus_io.instr_valid_o = is_drain;
        bus_io.instr_last_o  = is_last;
        bus_io.instr_o       = is_drain ?
                               pkt_q[idx_q * CORE_INSTR_SINGLE_WIDTH +: CORE_INSTR_SINGLE_WIDTH] :
                               '0;
        bus_io.instr_pc_o    = is_drain ?
                               base_pc_q + (CORE_PC_WIDTH'(idx_q) << 2) :
                               '0;

        // Refill only when empty or when the final slot leaves this cycle
        bus_io.pkt_ready_o   = !rst && !bus_io.flush_i &&
                               (!is_drain || (is_last && bus_io.instr_ready_i));

        pkt_fire   = bus_io.pkt_valid_i && bus_io.pkt_ready_o;
        instr_fire = is_drain && bus_io.instr_ready_i;
    end

    // Next-state: flush beats packet load, which beats advancing the slot index
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        base_pc_d = base_pc_q;
        idx_d     = idx_q;

        if (bus_io.flush_i) begin
            state_d = StIdle;
        end else if (pkt_fire) begin
            state_d   = StDrain;
            pkt_d     = bus_io.pkt_data_i;
            base_pc_d = bus_io.pkt_pc_i;
            idx_d     = bus_io.pkt_start_i;
        end else if (instr_fire) begin
            if (idx_q == LastIdx) begin
                state_d = StIdle;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    // State and buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pkt_q     <= '0;
            base_pc_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            base_pc_q <= base_pc_d;
            idx_q     <= idx_d;
        end
    end
endmodule

// File: tb/tb_instr_unpacker.sv
// Directed self-checking bench for instr_unpacker.
module tb_instr_unpacker;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [127:0] p1, pa, pb, p2, p3, p4, p5, p6, p7;

    instr_unpacker_if bus ();

    instr_unpacker dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [127:0] d, input logic [31:0] pc, input logic [1:0] st);
        bus.pkt_valid_i = 1'b1;
        bus.pkt_data_i  = d;
        bus.pkt_pc_i    = pc;
        bus.pkt_start_i = st;
    endtask

    task automatic exp_instr(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                             input logic last);
        check_eq({tag, ".valid"}, 32'(bus.instr_valid_o), 32'd1);
        check_eq({tag, ".instr"}, bus.instr_o, ins);
        check_eq({tag, ".pc"}, bus.instr_pc_o, pc);
        check_eq({tag, ".last"}, 32'(bus.instr_last_o), 32'(last));
    endtask

    // One instruction per cycle from slot 'first' to 3, with ready held high
    task automatic drain(input string tag, input logic [127:0] d, input logic [31:0] pc,
                         input int first, input logic offer_nxt, input logic [127:0] nd,
                         input logic [31:0] npc);
        for (int i = first; i < 4; i++) begin
            tick();
            bus.pkt_valid_i = offer_nxt;
            bus.pkt_data_i  = nd;
            bus.pkt_pc_i    = npc;
            bus.pkt_start_i = 2'd0;
            #1;
            exp_instr($sformatf("%s.s%0d", tag, i), d[32*i +: 32], pc + 32'(4 * i), i == 3);
            check_eq($sformatf("%s.s%0d.pkt_rdy", tag, i), 32'(bus.pkt_ready_o), 32'(i == 3));
        end
    endtask

    task automatic idle_chk(input string tag);
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        check_eq({tag, ".idle_valid"}, 32'(bus.instr_valid_o), 32'd0);
        check_eq({tag, ".idle_rdy"}, 32'(bus.pkt_ready_o), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        p1 = {32'h33, 32'h22, 32'h11, 32'h00};
        pa = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        pb = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        p2 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        p3 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        p4 = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        p5 = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        p6 = {32'h63, 32'h62, 32'h61, 32'h60};
        p7 = {32'h73, 32'h72, 32'h71, 32'h70};

        rst               = 1'b1;
        bus.pkt_valid_i   = 1'b0;
        bus.pkt_data_i    = '0;
        bus.pkt_pc_i      = '0;
        bus.pkt_start_i   = '0;
        bus.flush_i       = 1'b0;
        bus.instr_ready_i = 1'b1;

        // Reset
        tick();
        #1;
        check_eq("rst.pkt_rdy", 32'(bus.pkt_ready_o), 32'd0);
        check_eq("rst.valid", 32'(bus.instr_valid_o), 32'd0);
        check_eq("rst.instr", bus.instr_o, 32'd0);
        check_eq("rst.pc", bus.instr_pc_o, 32'd0);
        check_eq("rst.last", 32'(bus.instr_last_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst.rdy_after", 32'(bus.pkt_ready_o), 32'd1);

        // Single packet, start 0
        tick();
        offer(p1, 32'h1000, 2'd0);
        #1;
        check_eq("p1.rdy_idle", 32'(bus.pkt_ready_o), 32'd1);
        drain("p1", p1, 32'h1000, 0, 1'b0, '0, '0);
        idle_chk("p1");

        // Back-to-back packets, second accepted on slot 3 of first
        tick();
        offer(pa, 32'h1000, 2'd0);
        #1;
        drain("b2bA", pa, 32'h1000, 0, 1'b1, pb, 32'h1010);
        drain("b2bB", pb, 32'h1010, 0, 1'b0, '0, '0);
        idle_chk("b2b");

        // Start inside the packet
        tick();
        offer(p2, 32'h2000, 2'd2);
        #1;
        drain("st2", p2, 32'h2000, 2, 1'b0, '0, '0);
        idle_chk("st2");
        tick();
        offer(p2, 32'h2000, 2'd3);
        #1;
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        exp_instr("st3", 32'hC3, 32'h200C, 1'b1);
        idle_chk("st3");

        // Back-pressure at slot 1
        tick();
        offer(p3, 32'h3000, 2'd0);
        #1;
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        exp_instr("stall.s0", 32'hD0, 32'h3000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.instr_ready_i = 1'b0;
            bus.pkt_valid_i   = 1'b1;
            #1;
            exp_instr($sformatf("stall.hold%0d", k), 32'hD1, 32'h3004, 1'b0);
            check_eq($sformatf("stall.pkt_rdy%0d", k), 32'(bus.pkt_ready_o), 32'd0);
        end
        tick();
        bus.instr_ready_i = 1'b1;
        bus.pkt_valid_i   = 1'b0;
        #1;
        exp_instr("stall.resume", 32'hD1, 32'h3004, 1'b0);
        drain("stall", p3, 32'h3000, 2, 1'b0, '0, '0);
        idle_chk("stall");

        // Flush during slot 2 with a packet on offer
        tick();
        offer(p4, 32'h4000, 2'd0);
        #1;
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        exp_instr("fl.s0", 32'hE0, 32'h4000, 1'b0);
        tick();
        #1;
        exp_instr("fl.s1", 32'hE1, 32'h4004, 1'b0);
        tick();
        offer(p5, 32'h5000, 2'd0);
        bus.flush_i = 1'b1;
        #1;
        exp_instr("fl.s2", 32'hE2, 32'h4008, 1'b0);
        check_eq("fl.pkt_rdy_flush", 32'(bus.pkt_ready_o), 32'd0);
        tick();
        bus.flush_i = 1'b0;
        #1;
        check_eq("fl.valid_after", 32'(bus.instr_valid_o), 32'd0);
        check_eq("fl.pkt_rdy_after", 32'(bus.pkt_ready_o), 32'd1);
        drain("fl.new", p5, 32'h5000, 0, 1'b0, '0, '0);
        idle_chk("fl");

        // PC wrap-around
        tick();
        offer(p6, 32'hFFFF_FFF8, 2'd0);
        #1;
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        exp_instr("wrap.s0", 32'h60, 32'hFFFF_FFF8, 1'b0);
        tick();
        #1;
        exp_instr("wrap.s1", 32'h61, 32'hFFFF_FFFC, 1'b0);
        tick();
        #1;
        exp_instr("wrap.s2", 32'h62, 32'h0000_0000, 1'b0);
        tick();
        #1;
        exp_instr("wrap.s3", 32'h63, 32'h0000_0004, 1'b1);
        idle_chk("wrap");

        // Reset mid-drain
        tick();
        offer(p7, 32'h6000, 2'd0);
        #1;
        tick();
        bus.pkt_valid_i = 1'b0;
        #1;
        exp_instr("mrst.s0", 32'h70, 32'h6000, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_eq("mrst.pkt_rdy_in", 32'(bus.pkt_ready_o), 32'd0);
        tick();
        #1;
        check_eq("mrst.valid", 32'(bus.instr_valid_o), 32'd0);
        check_eq("mrst.instr", bus.instr_o, 32'd0);
        check_eq("mrst.pc", bus.instr_pc_o, 32'd0);
        check_eq("mrst.last", 32'(bus.instr_last_o), 32'd0);
        check_eq("mrst.pkt_rdy", 32'(bus.pkt_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst.rdy_after", 32'(bus.pkt_ready_o), 32'd1);
        check_eq("mrst.valid_after", 32'(bus.instr_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
